// File: rtl/pmp_csr_regs_if.sv
// CSR-unit to PMP register file access bus: strobes, address and write data in; read data and hit out.
// Read data and hit are combinational. The bus has no stall path.
interface pmp_csr_regs_if #(
  parameter int XLEN = 64
);
  logic            csr_we;
  logic            csr_re;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_hit;

  modport master (
    output csr_we, csr_re, csr_addr, csr_wdata,
    input  csr_rdata, csr_hit
  );

  modport slave (
    input  csr_we, csr_re, csr_addr, csr_wdata,
    output csr_rdata, csr_hit
  );
endinterface

// File: rtl/pmp_csr_regs.sv
// PMP pmpcfg/pmpaddr register file with WARL legalisation and lock rules. Writes land on the next edge, reads are combinational, and it never stalls.
// Define PMP_NA4_EN to keep A=NA4 as written; otherwise G>=1 (NA4 stores OFF and NAPOT reads return pmpaddr bit 0 set).
module pmp_csr_regs #(
  parameter int XLEN       = 64,
  parameter int PMP_LEN    = 54,
  parameter int NR_ENTRIES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  pmp_csr_regs_if.slave             csr,
  output logic                      pmp_update_o,
  output logic [15:0][PMP_LEN-1:0]  conf_addr_o,
  output logic [15:0][7:0]          conf_o
);

  localparam int          NB      = XLEN / 8;
  localparam logic [1:0]  A_OFF   = 2'd0;
  localparam logic [1:0]  A_TOR   = 2'd1;
  localparam logic [1:0]  A_NA4   = 2'd2;
  localparam logic [1:0]  A_NAPOT = 2'd3;
  localparam logic [15:0] IMPL    = (NR_ENTRIES >= 16) ? 16'hFFFF
                                                       : 16'((32'd1 << NR_ENTRIES) - 32'd1);

  logic [15:0][7:0]         cfg_q, cfg_d;
  logic [15:0][PMP_LEN-1:0] addr_q, addr_d;
  logic                     upd_q, upd_d;

  logic            cfg_hit, addr_hit, hit;
  logic [3:0]      cfg_base, addr_idx, ent;
  logic [15:0]     lock, tor_lock, addr_lock;
  logic [XLEN-1:0] rdata;

  function automatic logic [7:0] legalise(input logic [7:0] b);
    logic [7:0] l;
    l = b & 8'h9F;
    if (!l[0]) l[1] = 1'b0;
`ifndef PMP_NA4_EN
    if (l[4:3] == A_NA4) l[4:3] = A_OFF;
`endif
    return l;
  endfunction

  // On RV64 only the even pmpcfg numbers exist; each covers eight entries.
  always_comb begin
    cfg_hit  = (csr.csr_addr[11:2] == 10'h0E8) && ((XLEN == 64) ? !csr.csr_addr[0] : 1'b1);
    addr_hit = (csr.csr_addr[11:4] == 8'h3B);
    hit      = cfg_hit || addr_hit;
    cfg_base = {csr.csr_addr[1:0], 2'b00};
    addr_idx = csr.csr_addr[3:0];
  end

  // An unimplemented entry holds zero, so its TOR lock bit never blocks the entry below it.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      lock[i]     = cfg_q[i][7];
      tor_lock[i] = cfg_q[i][7] && (cfg_q[i][4:3] == A_TOR);
    end
    addr_lock = ~IMPL | lock | {1'b0, tor_lock[15:1]};
  end

  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    upd_d  = 1'b0;
    ent    = '0;
    if (csr.csr_we && hit && !rst_i) begin
      if (cfg_hit) begin
        for (int b = 0; b < NB; b++) begin
          ent = cfg_base + 4'(b);
          if (IMPL[ent] && !lock[ent]) begin
            cfg_d[ent] = legalise(csr.csr_wdata[8*b +: 8]);
            upd_d      = 1'b1;
          end
        end
      end else if (!addr_lock[addr_idx]) begin
        addr_d[addr_idx] = csr.csr_wdata[PMP_LEN-1:0];
        upd_d            = 1'b1;
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (!IMPL[i]) begin
        cfg_d[i]  = '0;
        addr_d[i] = '0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (csr.csr_re && hit) begin
      if (cfg_hit) begin
        for (int b = 0; b < NB; b++) rdata[8*b +: 8] = cfg_q[cfg_base + 4'(b)];
      end else begin
        rdata[PMP_LEN-1:0] = addr_q[addr_idx];
`ifndef PMP_NA4_EN
        if (cfg_q[addr_idx][4:3] == A_NAPOT) rdata[0] = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q  <= '0;
      addr_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
      upd_q  <= upd_d;
    end
  end

  assign csr.csr_rdata = rdata;
  assign csr.csr_hit   = hit;
  assign pmp_update_o  = upd_q;
  assign conf_addr_o   = addr_q;
  assign conf_o        = cfg_q;

endmodule
